// File: rtl/img_frame_reader.sv
// rtl/img_frame_reader.sv - sequential frame-buffer reader emitting a valid/ready pixel stream
// Tags (line end / frame end) are computed at read issue and travel with the returned data.
module img_frame_reader #(
  parameter int K_IMG_INPUT = 76800,
  parameter int K_H_SYNC    = 320,
  parameter int K_V_SYNC    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [19:0] img_read_addr,
  output logic        img_rd_enb,
  input  logic [7:0]  img_read_data,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        hsync,
  output logic        vsync,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, state_n;
  logic        start_d;
  logic        inflight, infl_h, infl_v;
  logic [15:0] hcnt, vcnt;
  logic        tail_valid, tail_h, tail_v;
  logic [7:0]  tail_data;

  logic        pop, start_edge, last_addr, h_tag, v_tag, rd_ok;
  logic [1:0]  occ;

  assign pop        = pix_valid && pix_ready;
  assign start_edge = start && !start_d;
  assign last_addr  = (img_read_addr == 20'(K_IMG_INPUT - 1));
  assign h_tag      = (hcnt == 16'(K_H_SYNC - 1));
  assign v_tag      = h_tag && (vcnt == 16'(K_V_SYNC - 1));
  assign occ        = {1'b0, pix_valid} + {1'b0, tail_valid};
  // Room check counts the slot freed by a same-cycle pop, so a full stream runs at one beat per cycle.
  assign rd_ok      = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    img_rd_enb = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start_edge) state_n = RUN;
      RUN: begin
        busy       = 1'b1;
        img_rd_enb = rd_ok;
        if (rd_ok && last_addr) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && vsync) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_d       <= 1'b0;
      inflight      <= 1'b0;
      infl_h        <= 1'b0;
      infl_v        <= 1'b0;
      img_read_addr <= '0;
      hcnt          <= '0;
      vcnt          <= '0;
    end else begin
      start_d  <= start;
      inflight <= img_rd_enb;
      if (state == IDLE && start_edge) begin
        img_read_addr <= '0;
        hcnt          <= '0;
        vcnt          <= '0;
      end else if (img_rd_enb) begin
        infl_h <= h_tag;
        infl_v <= v_tag;
        if (!last_addr) img_read_addr <= img_read_addr + 20'd1;
        if (h_tag) begin
          hcnt <= '0;
          vcnt <= vcnt + 16'd1;
        end else begin
          hcnt <= hcnt + 16'd1;
        end
      end
    end
  end

  // Two-entry buffer: head drives the outputs directly, tail holds the second entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
      tail_h     <= 1'b0;
      tail_v     <= 1'b0;
    end else if (pop) begin
      if (tail_valid) begin
        pix_data <= tail_data;
        hsync    <= tail_h;
        vsync    <= tail_v;
        if (inflight) begin
          tail_data <= img_read_data;
          tail_h    <= infl_h;
          tail_v    <= infl_v;
        end else begin
          tail_valid <= 1'b0;
        end
      end else if (inflight) begin
        pix_data <= img_read_data;
        hsync    <= infl_h;
        vsync    <= infl_v;
      end else begin
        pix_valid <= 1'b0;
      end
    end else if (inflight) begin
      if (!pix_valid) begin
        pix_valid <= 1'b1;
        pix_data  <= img_read_data;
        hsync     <= infl_h;
        vsync     <= infl_v;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= img_read_data;
        tail_h     <= infl_h;
        tail_v     <= infl_v;
      end
    end
  end

endmodule

// File: tb/tb_img_frame_reader.sv
// tb/tb_img_frame_reader.sv - scoreboard bench for img_frame_reader
// Small 4x3 frame instance for directed tests, full-size instance for the long frame.
module tb_img_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, pix_ready;
  logic [19:0] addr;
  logic        rd;
  logic [7:0]  rdata = 8'd0;
  logic [7:0]  pdata;
  logic        pvalid, hs, vs, busy, done;

  logic        start2, ready2;
  logic [19:0] addr2;
  logic        rd2;
  logic [7:0]  rdata2 = 8'd0;
  logic [7:0]  pdata2;
  logic        pv2, hs2, vs2, busy2, done2;

  img_frame_reader #(.K_IMG_INPUT(12), .K_H_SYNC(4), .K_V_SYNC(3)) u_small (
    .clk(clk), .reset(reset), .start(start), .img_read_addr(addr), .img_rd_enb(rd),
    .img_read_data(rdata), .pix_data(pdata), .pix_valid(pvalid), .pix_ready(pix_ready),
    .hsync(hs), .vsync(vs), .busy(busy), .done(done));

  img_frame_reader u_big (
    .clk(clk), .reset(reset), .start(start2), .img_read_addr(addr2), .img_rd_enb(rd2),
    .img_read_data(rdata2), .pix_data(pdata2), .pix_valid(pv2), .pix_ready(ready2),
    .hsync(hs2), .vsync(vs2), .busy(busy2), .done(done2));

  always @(posedge clk) begin
    if (rd)  rdata  <= addr[7:0] + 8'd16;
    if (rd2) rdata2 <= addr2[7:0];
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Full-size frame statistics
  int b2_beats = 0, hs_cnt = 0, hs_bad = 0, vs_cnt = 0, vs_idx = -1;
  int max_addr2 = 0;
  bit done2_seen = 0;
  always @(negedge clk) begin
    if (pv2 && ready2) begin
      if (hs2 !== ((b2_beats % 320) == 319)) hs_bad++;
      if (hs2) hs_cnt++;
      if (vs2) begin vs_cnt++; vs_idx = b2_beats; end
      b2_beats++;
    end
    if (rd2 && int'(addr2) > max_addr2) max_addr2 = int'(addr2);
    if (done2) done2_seen = 1;
  end

  logic [9:0] sb[$];
  int rel, rd_cnt, beats, first_rd, first_beat, last_beat, busy_cnt, busy_first;
  int done_cnt, done_cyc, exp_addr, n_out;
  bit prev_stall;
  logic [7:0] prev_data;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic clear_stats();
    rel = 0; rd_cnt = 0; beats = 0; first_rd = -1; first_beat = -1; last_beat = -1;
    busy_cnt = 0; busy_first = -1; done_cnt = 0; done_cyc = -1; exp_addr = 0; n_out = 0;
    prev_stall = 0; sb.delete();
  endtask

  task automatic push_frame();
    for (int i = 0; i < 12; i++)
      sb.push_back({8'(i + 16), 1'((i % 4) == 3), 1'(i == 11)});
  endtask

  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", pvalid, 1);
      check("stall_data", pdata, prev_data);
    end
    prev_stall = pvalid && !pix_ready;
    prev_data  = pdata;
    if (rd) begin
      check("rd_addr", addr, exp_addr);
      if (rd_cnt == 0) first_rd = rel;
      rd_cnt++; exp_addr++; n_out++;
    end
    if (pvalid && pix_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("pix_data", pdata, e[9:2]);
        check("hsync", hs, e[1]);
        check("vsync", vs, e[0]);
      end
      if (beats == 0) first_beat = rel;
      last_beat = rel;
      beats++; n_out--;
    end
    if (rd) check("outstanding_le2", n_out <= 2, 1);
    if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = rel; end
    if (done) begin done_cnt++; done_cyc = rel; end
    rel++;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_pdata"}, pdata, 0);
    check({tag, "_pvalid"}, pvalid, 0);
    check({tag, "_hsync"}, hs, 0);
    check({tag, "_vsync"}, vs, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_frame();
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1; start2 = 1'b0; ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Free-running frame
    clear_stats();
    run_frame();
    check("t1_first_rd", first_rd, 1);
    check("t1_rd_cnt", rd_cnt, 12);
    check("t1_first_beat", first_beat, 3);
    check("t1_last_beat", last_beat, 14);
    check("t1_done_cyc", done_cyc, 15);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_first", busy_first, 1);
    check("t1_busy_cnt", busy_cnt, 14);
    check("t1_sb_empty", sb.size(), 0);

    // Ready toggling 1,0,0,1
    clear_stats();
    push_frame();
    start = 1'b1; pix_ready = pat[0]; tick(); start = 1'b0;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      pix_ready = pat[rel % 4];
      tick();
    end
    check("t2_beats", beats, 12);
    check("t2_rd_cnt", rd_cnt, 12);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_sb_empty", sb.size(), 0);
    pix_ready = 1'b1; tick();

    // Ready held low from start
    clear_stats();
    push_frame();
    pix_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    check("t3_rd_cnt_stalled", rd_cnt, 2);
    check("t3_beats_stalled", beats, 0);
    pix_ready = 1'b1;
    repeat (20) tick();
    check("t3_beats", beats, 12);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_sb_empty", sb.size(), 0);

    // Long start level plus an extra edge while busy
    clear_stats();
    push_frame();
    start = 1'b1; repeat (5) tick();
    start = 1'b0; tick();
    start = 1'b1; repeat (34) tick();
    start = 1'b0; repeat (5) tick();
    check("t4_rd_cnt", rd_cnt, 12);
    check("t4_beats", beats, 12);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_sb_empty", sb.size(), 0);
    clear_stats();
    run_frame();
    check("t4b_first_rd", first_rd, 1);
    check("t4b_rd_cnt", rd_cnt, 12);
    check("t4b_beats", beats, 12);
    check("t4b_done_cnt", done_cnt, 1);
    check("t4b_sb_empty", sb.size(), 0);

    // Reset mid-frame
    clear_stats();
    push_frame();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30 && beats < 5; i++) tick();
    check("t5_beats_before_reset", beats, 5);
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_outputs("t5");
    clear_stats();
    repeat (10) tick();
    check("t5_no_done", done_cnt, 0);
    check("t5_no_rd", rd_cnt, 0);
    clear_stats();
    run_frame();
    check("t5_first_rd", first_rd, 1);
    check("t5_first_beat", first_beat, 3);
    check("t5_beats", beats, 12);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_sb_empty", sb.size(), 0);

    // Full-size frame
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 77000 && !done2_seen; i++) tick();
    check("big_done", done2_seen, 1);
    check("big_beats", b2_beats, 76800);
    check("big_hs_cnt", hs_cnt, 240);
    check("big_hs_bad", hs_bad, 0);
    check("big_vs_cnt", vs_cnt, 1);
    check("big_vs_idx", vs_idx, 76799);
    check("big_max_addr", max_addr2, 76799);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
